// File: rtl/ext_reset_seq_if.sv
// Request/response bundle for ext_reset_seq: host reset-request flags in,
// per-channel reset outputs and sequence status out.
interface ext_reset_seq_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] host_rst_flag;
    logic [NUM_CH-1:0] ext_reset_in;
    logic              busy;
    logic              done;
    logic [NUM_CH-1:0] active_mask;

    modport master (
        output host_rst_flag,
        input  ext_reset_in,
        input  busy,
        input  done,
        input  active_mask
    );

    modport slave (
        input  host_rst_flag,
        output ext_reset_in,
        output busy,
        output done,
        output active_mask
    );
endinterface

// File: rtl/ext_reset_seq.sv
// Multi-channel external reset pulse sequencer. Define EXT_RST_STAGGER_EN to
// release channels one at a time (lowest index first, GAP_CYC apart).
module ext_reset_seq #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int PULSE_CYC = 10,
    parameter int GAP_CYC   = 4
) (
    input  logic            slowest_sync_clk,
    input  logic            ui_clk_sync_rst_n,
    ext_reset_seq_if.slave  bus
);

`ifdef EXT_RST_STAGGER_EN
    typedef enum logic [1:0] {IDLE, ASSERT, RELEASE} state_t;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
`else
    typedef enum logic [1:0] {IDLE, ASSERT} state_t;
`endif
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);

    if (NUM_CH < 1 || NUM_CH > 16 ||
        PULSE_CYC < 1 || longint'(PULSE_CYC) >= (64'd1 << CNT_W) ||
        GAP_CYC < 1 || longint'(GAP_CYC) >= (64'd1 << CNT_W)) begin : g_param_err
        $error("ext_reset_seq: parameter out of range");
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;
    logic [NUM_CH-1:0] sync2_dly_q, sync2_dly_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] ext_q, ext_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NUM_CH-1:0] rise;
`ifdef EXT_RST_STAGGER_EN
    logic [NUM_CH-1:0] remaining;
`endif

    always_ff @(posedge slowest_sync_clk or negedge ui_clk_sync_rst_n) begin
        if (!ui_clk_sync_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync2_dly_q <= '0;
            pending_q   <= '0;
            ext_q       <= '1;
            mask_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync2_dly_q <= sync2_dly_d;
            pending_q   <= pending_d;
            ext_q       <= ext_d;
            mask_q      <= mask_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        sync1_d     = bus.host_rst_flag;
        sync2_d     = sync1_q;
        sync2_dly_d = sync2_q;
        rise        = sync2_q & ~sync2_dly_q;

        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        pending_d = pending_q | rise;
        ext_d     = ext_q;
        mask_d    = mask_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef EXT_RST_STAGGER_EN
        // ext_q doubles as the working copy: bits still held in reset.
        remaining = ext_q & (ext_q - 1'b1);
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                ext_d = '0;
                if (pending_q != '0) begin
                    state_d   = ASSERT;
                    mask_d    = pending_q;
                    ext_d     = pending_q;
                    busy_d    = 1'b1;
                    // Whole mask captured; a same-edge rise must stay queued.
                    pending_d = rise;
                end
            end
            ASSERT: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d = '0;
`ifdef EXT_RST_STAGGER_EN
                    ext_d = remaining;
                    if (remaining == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        mask_d  = '0;
                    end else begin
                        state_d = RELEASE;
                    end
`else
                    ext_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    mask_d  = '0;
`endif
                end
            end
`ifdef EXT_RST_STAGGER_EN
            RELEASE: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    ext_d = remaining;
                    if (remaining == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        mask_d  = '0;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign bus.ext_reset_in = ext_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.active_mask  = mask_q;

endmodule

// File: tb/tb_ext_reset_seq.sv
// Scoreboard bench for ext_reset_seq: stimulus queues timestamped output
// changes, negedge monitors pop and compare on every observed change.
module tb_ext_reset_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ext_reset_seq_if #(.NUM_CH(4)) bus_a ();
    ext_reset_seq_if #(.NUM_CH(1)) bus_b ();

    ext_reset_seq #(.NUM_CH(4), .CNT_W(16), .PULSE_CYC(10), .GAP_CYC(4)) dut_a (
        .slowest_sync_clk (clk),
        .ui_clk_sync_rst_n(rst_n),
        .bus              (bus_a.slave)
    );

    ext_reset_seq #(.NUM_CH(1), .CNT_W(16), .PULSE_CYC(1), .GAP_CYC(4)) dut_b (
        .slowest_sync_clk (clk),
        .ui_clk_sync_rst_n(rst_n),
        .bus              (bus_b.slave)
    );

    typedef struct {
        int         cyc;
        logic [9:0] val;
    } evt_t;

    evt_t q_a[$];
    evt_t q_b[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    logic [9:0] prev_a, prev_b;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] pk_a(logic [3:0] e, logic b, logic d, logic [3:0] m);
        return {e, b, d, m};
    endfunction

    function automatic logic [9:0] pk_b(logic e, logic b, logic d, logic m);
        return {6'b0, e, b, d, m};
    endfunction

    task automatic check(input string nm, input int act_cyc, input int exp_cyc,
                         input logic [9:0] act, input logic [9:0] exp_v);
        checks++;
        if (act !== exp_v || act_cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s: got cyc=%0d val=%b, expected cyc=%0d val=%b",
                     nm, act_cyc, act, exp_cyc, exp_v);
        end else begin
            $display("ok   %s: cyc=%0d val=%b", nm, act_cyc, act);
        end
    endtask

    task automatic exp_a(input int c, input logic [3:0] e, input logic b,
                         input logic d, input logic [3:0] m);
        evt_t ev;
        ev.cyc = c;
        ev.val = pk_a(e, b, d, m);
        q_a.push_back(ev);
    endtask

    task automatic exp_b(input int c, input logic e, input logic b,
                         input logic d, input logic m);
        evt_t ev;
        ev.cyc = c;
        ev.val = pk_b(e, b, d, m);
        q_b.push_back(ev);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        logic [9:0] cur;
        evt_t ev;
        cur = pk_a(bus_a.ext_reset_in, bus_a.busy, bus_a.done, bus_a.active_mask);
        if (mon_en && cur !== prev_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_a_unexpected: got cyc=%0d val=%b, expected no change", cyc, cur);
            end else begin
                ev = q_a.pop_front();
                check("mon_a", cyc, ev.cyc, cur, ev.val);
            end
        end
        prev_a = cur;
    end

    always @(negedge clk) begin
        logic [9:0] cur;
        evt_t ev;
        cur = pk_b(bus_b.ext_reset_in[0], bus_b.busy, bus_b.done, bus_b.active_mask[0]);
        if (mon_en && cur !== prev_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_b_unexpected: got cyc=%0d val=%b, expected no change", cyc, cur);
            end else begin
                ev = q_b.pop_front();
                check("mon_b", cyc, ev.cyc, cur, ev.val);
            end
        end
        prev_b = cur;
    end

    initial begin
        int e0;
        bus_a.host_rst_flag = '0;
        bus_b.host_rst_flag = '0;
        rst_n = 1'b0;

        // Held in reset: all channels asserted, status idle.
        tick(3);
        check("rst_state_a", cyc, cyc,
              pk_a(bus_a.ext_reset_in, bus_a.busy, bus_a.done, bus_a.active_mask),
              pk_a(4'b1111, 1'b0, 1'b0, 4'b0000));
        check("rst_state_b", cyc, cyc,
              pk_b(bus_b.ext_reset_in[0], bus_b.busy, bus_b.done, bus_b.active_mask[0]),
              pk_b(1'b1, 1'b0, 1'b0, 1'b0));

        exp_a(cyc + 1, 4'b0000, 1'b0, 1'b0, 4'b0000);
        exp_b(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick(4);

        // Single channel held high: one pulse only.
        e0 = cyc + 1;
        bus_a.host_rst_flag = 4'b0010;
        exp_a(e0 + 3,  4'b0010, 1'b1, 1'b0, 4'b0010);
        exp_a(e0 + 13, 4'b0000, 1'b0, 1'b1, 4'b0000);
        exp_a(e0 + 14, 4'b0000, 1'b0, 1'b0, 4'b0000);
        tick(30);
        bus_a.host_rst_flag = 4'b0000;
        tick(5);

        // Two channels on the same edge.
        e0 = cyc + 1;
        bus_a.host_rst_flag = 4'b0101;
        exp_a(e0 + 3,  4'b0101, 1'b1, 1'b0, 4'b0101);
`ifdef EXT_RST_STAGGER_EN
        exp_a(e0 + 13, 4'b0100, 1'b1, 1'b0, 4'b0101);
        exp_a(e0 + 17, 4'b0000, 1'b0, 1'b1, 4'b0000);
        exp_a(e0 + 18, 4'b0000, 1'b0, 1'b0, 4'b0000);
`else
        exp_a(e0 + 13, 4'b0000, 1'b0, 1'b1, 4'b0000);
        exp_a(e0 + 14, 4'b0000, 1'b0, 1'b0, 4'b0000);
`endif
        tick(25);
        bus_a.host_rst_flag = 4'b0000;
        tick(5);

        // Re-request ch0 during its own sequence: back-to-back sequences.
        e0 = cyc + 1;
        bus_a.host_rst_flag = 4'b0001;
        exp_a(e0 + 3,  4'b0001, 1'b1, 1'b0, 4'b0001);
        exp_a(e0 + 13, 4'b0000, 1'b0, 1'b1, 4'b0000);
        exp_a(e0 + 14, 4'b0001, 1'b1, 1'b0, 4'b0001);
        exp_a(e0 + 24, 4'b0000, 1'b0, 1'b1, 4'b0000);
        exp_a(e0 + 25, 4'b0000, 1'b0, 1'b0, 4'b0000);
        tick(3);
        bus_a.host_rst_flag = 4'b0000;
        tick(3);
        bus_a.host_rst_flag = 4'b0001;
        tick(25);
        bus_a.host_rst_flag = 4'b0000;
        tick(5);

        // Reset mid-pulse with another request pending.
        e0 = cyc + 1;
        bus_a.host_rst_flag = 4'b1000;
        exp_a(e0 + 3, 4'b1000, 1'b1, 1'b0, 4'b1000);
        tick(3);
        bus_a.host_rst_flag = 4'b1010;
        tick(5);
        exp_a(cyc, 4'b1111, 1'b0, 1'b0, 4'b0000);
        exp_b(cyc, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        bus_a.host_rst_flag = 4'b0000;
        #1;
        check("async_rst_a", cyc, cyc, {6'b0, bus_a.ext_reset_in}, 10'b0000001111);
        tick(3);
        exp_a(cyc + 1, 4'b0000, 1'b0, 1'b0, 4'b0000);
        exp_b(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(25);

        // Single channel, one-clock pulse.
        e0 = cyc + 1;
        bus_b.host_rst_flag = 1'b1;
        exp_b(e0 + 3, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_b(e0 + 4, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_b(e0 + 5, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(10);
        bus_b.host_rst_flag = 1'b0;
        tick(5);

        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL drain_a: got %0d events outstanding, expected 0 (next cyc=%0d)",
                     q_a.size(), q_a[0].cyc);
        end
        checks++;
        if (q_b.size() != 0) begin
            errors++;
            $display("FAIL drain_b: got %0d events outstanding, expected 0 (next cyc=%0d)",
                     q_b.size(), q_b[0].cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ext_reset_seq.md
# ext_reset_seq

Multi-channel successor to the single-channel external-reset pulse generator. It sits in the `slowest_sync_clk` domain between the host reset-request flags and the `ext_reset_in` inputs of the downstream processor-system-reset blocks. Each channel's request is synchronised and edge-detected; a rising edge queues that channel. Queued channels then get one common reset pulse of programmable width, followed by an optional staggered release in channel-index order.

## Interface
- `NUM_CH`, 4: number of reset channels, 1..16.
- `CNT_W`, 16: width of the pulse/gap counter.
- `PULSE_CYC`, 10: reset pulse width in clocks, 1..2^CNT_W-1.
- `GAP_CYC`, 4: clocks between successive channel releases in staggered mode, 1..2^CNT_W-1.
- `slowest_sync_clk`, in, 1: sole clock, rising edge.
- `ui_clk_sync_rst_n`, in, 1: asynchronous, active-low reset.
- `host_rst_flag`, in, NUM_CH: per-channel reset request, level. Asynchronous to the clock.
- `ext_reset_in`, out, NUM_CH: per-channel reset output, active-high, registered.
- `busy`, out, 1: sequence in progress.
- `done`, out, 1: one-cycle pulse when a sequence completes.
- `active_mask`, out, NUM_CH: channels in the current sequence. Zero when idle.

## Operation
- Reset asserted (`ui_clk_sync_rst_n`=0):
  - `ext_reset_in` = all ones, so downstream is held in reset.
  - `busy`=0, `done`=0, `active_mask`=0.
  - Synchronisers, pending mask, counter and FSM are all cleared; FSM=IDLE.
- First edge after reset release: `ext_reset_in` goes to 0.
- Request path:
  - Each `host_rst_flag[i]` goes through a 2-flop synchroniser (`s2`), then a delay flop (`s2_d`).
  - `rise[i] = s2 & ~s2_d`. On `rise[i]`, `pending[i]` is set.
  - A held-high flag never re-triggers; the flag must drop and rise again to re-arm.
- FSM states:
  - **IDLE**: if `pending != 0`, go to ASSERT. On that edge:
    - `active_mask <= pending`; `ext_reset_in <= pending`; `busy <= 1`; counter <= 0.
    - `pending <= rise` (only the bits of the captured pending mask are cleared, so a same-edge rise re-queues its channel).
  - **ASSERT**: counter increments each clock. When counter == PULSE_CYC-1:
    - Staggered mode: go to RELEASE and clear the lowest set bit of `ext_reset_in` and of a working copy of the mask; counter <= 0. If that was the only bit set, go directly to IDLE as in the last-release case below.
    - Non-staggered mode: clear all active bits and go to IDLE.
  - **RELEASE**: counter increments each clock. When counter == GAP_CYC-1, clear the next-lowest remaining bit; counter <= 0. When the last bit clears, go to IDLE.
- On entering IDLE from a sequence, on the same edge:
  - `done <= 1` for one cycle.
  - `busy <= 0`.
  - `active_mask <= 0`.
- Rises arriving while busy, including on already-active channels, accumulate in `pending`. They are served by the next sequence, which starts one clock after the IDLE entry.
- Channels not in `active_mask` hold `ext_reset_in`=0 throughout a sequence.

## Timing
- Let E0 be the first edge that samples `host_rst_flag[i]` high.
  - E0+2: `pending[i]` set.
  - E0+3: `ext_reset_in[i]` rises and `busy` rises.
- Pulse width:
  - Non-staggered: exactly PULSE_CYC clocks; all active channels fall together at E0+3+PULSE_CYC.
  - Staggered: the k-th active channel (k=0 for the lowest index) falls at E0+3+PULSE_CYC+k·GAP_CYC.
- `done` is high in the cycle after the last release edge.
- Minimum spacing between sequences: 1 idle clock.
- Counter arithmetic is unsigned CNT_W and compared by equality. It never wraps within a legal parameter range.
- Reset asserted mid-sequence: all state is cleared at once and `ext_reset_in` goes to all ones asynchronously. Pending requests are dropped.

## Configuration
- `EXT_RST_STAGGER_EN` defined:
  - RELEASE state and `GAP_CYC` logic are compiled in.
  - Channels release lowest index first, GAP_CYC apart.
- `EXT_RST_STAGGER_EN` undefined:
  - RELEASE is absent; `GAP_CYC` is ignored.
  - All active channels release together after PULSE_CYC.

## Test plan
- Reset then release with default parameters: during reset, `ext_reset_in`=4'b1111; one edge after release, 4'b0000; `busy`=0.
- Pulse ch1 high from E0 and hold, non-staggered: `ext_reset_in`=4'b0010 from E0+3 for 10 clocks; `done` at E0+13; no second pulse while the flag stays high.
- Raise ch0 and ch2 on the same edge, staggered, GAP_CYC=4: both rise at E0+3; ch0 falls at E0+13; ch2 falls at E0+17; `active_mask`=4'b0101 while busy.
- Re-request ch0 at E0+6 during its own sequence: after `done`, a second sequence starts one clock later and `active_mask`=4'b0001.
- Assert reset at E0+7 mid-pulse: `ext_reset_in`=4'b1111 immediately; after release, the FSM is in IDLE and pending is empty, with no residual pulse.
- Parameter corner PULSE_CYC=1, NUM_CH=1: pulse is exactly 1 clock wide and `done` follows on the next edge.
